// File: rtl/data_mem_pkg.sv
// data_mem_pkg: widths and instruction-field offsets shared by the PE data memory.
// Latency: n/a (constants only).
// Backpressure: n/a.
package data_mem_pkg;

  localparam int DATA_WIDTH = 16;              // one scalar half
  localparam int INST_WIDTH = 64;              // PE instruction word
  localparam int ADDR_WIDTH = 8;               // each address field in inst
  localparam int DEPTH      = 2 ** ADDR_WIDTH; // entries in the array

  // Bit offsets of the address fields inside inst
  localparam int WADDR_LSB  = 16;
  localparam int RADDR1_LSB = 8;
  localparam int RADDR0_LSB = 0;

endpackage

// File: rtl/data_mem_ram_1w2r.sv
// data_mem_ram_1w2r: bare 1-write / 2-read array (distributed/LUT RAM style), no reset.
// Latency: write lands on the rising edge; reads are combinational from the array.
// Backpressure: none; every write completes on its edge.
//
// Ports:
//   clk            clock
//   we             write enable (already qualified by the parent)
//   waddr, wdata   write address / data
//   raddr0/raddr1  read addresses
//   rd0/rd1        unregistered read data; the parent registers them
module data_mem_ram_1w2r #(
  parameter int WIDTH = 32,
  parameter int AW    = 8
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr0,
  input  logic [AW-1:0]    raddr1,
  output logic [WIDTH-1:0] rd0,
  output logic [WIDTH-1:0] rd1
);

  logic [WIDTH-1:0] mem [2**AW];

  // Contents are deliberately never reset: they survive a reset pulse.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Async read of the pre-edge contents gives read-first behaviour once the
  // parent registers these on the same edge as the write.
  assign rd0 = mem[raddr0];
  assign rd1 = mem[raddr1];

endmodule

// File: rtl/data_mem.sv
// data_mem: per-PE operand memory, 1 write + 2 read ports, addresses decoded from inst.
// Latency: 1 cycle read (registered rdata0/rdata1); write visible to reads from the next edge.
// Backpressure: none; every enabled access completes in one cycle, outputs hold when rden=0.
//
// Ports:
//   clk     clock, rising edge
//   rst     async active-low reset; clears rdata0/rdata1 and blocks writes
//   wren    write enable; mem[inst[23:16]] <= wdata
//   rden    read enable; rdata0 <= mem[inst[7:0]], rdata1 <= mem[inst[15:8]]
//   inst    instruction word carrying the three address fields
//   wdata   write data (2*DATA_WIDTH)
//   rdata0  read port 0 data
//   rdata1  read port 1 data
module data_mem
  import data_mem_pkg::*;
#(
  parameter int DW = DATA_WIDTH,
  parameter int IW = INST_WIDTH,
  parameter int AW = ADDR_WIDTH
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wren,
  input  logic            rden,
  input  logic [IW-1:0]   inst,
  input  logic [2*DW-1:0] wdata,
  output logic [2*DW-1:0] rdata0,
  output logic [2*DW-1:0] rdata1
);

  logic [AW-1:0]   waddr;
  logic [AW-1:0]   raddr0;
  logic [AW-1:0]   raddr1;
  logic            we;
  logic [2*DW-1:0] ram_rd0;
  logic [2*DW-1:0] ram_rd1;

  assign waddr  = inst[WADDR_LSB  +: AW];
  assign raddr1 = inst[RADDR1_LSB +: AW];
  assign raddr0 = inst[RADDR0_LSB +: AW];

  // Remaining instruction bits belong to other PE units.
  logic unused_inst;
  assign unused_inst = ^inst[IW-1:WADDR_LSB+AW];

  // Gate with rst so a write on the edge that coincides with reset is dropped.
  assign we = wren & rst;

  data_mem_ram_1w2r #(
    .WIDTH (2*DW),
    .AW    (AW)
  ) u_ram (
    .clk    (clk),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .raddr0 (raddr0),
    .raddr1 (raddr1),
    .rd0    (ram_rd0),
    .rd1    (ram_rd1)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata0 <= '0;
      rdata1 <= '0;
    end else if (rden) begin
      rdata0 <= ram_rd0;
      rdata1 <= ram_rd1;
    end
  end

endmodule

// File: tb/tb_data_mem.sv
module tb_data_mem;

  logic        clk;
  logic        rst;
  logic        wren;
  logic        rden;
  logic [63:0] inst;
  logic [31:0] wdata;
  logic [31:0] rdata0;
  logic [31:0] rdata1;

  int errors = 0;
  int checks = 0;

  // Reference contents and which entries hold defined data.
  logic [31:0] model_mem [256];
  bit          model_vld [256];
  logic [63:0] exp_q [$];          // {rdata1, rdata0} expected per read
  logic [31:0] last0, last1;       // what the outputs should be holding

  data_mem dut (
    .clk    (clk),
    .rst    (rst),
    .wren   (wren),
    .rden   (rden),
    .inst   (inst),
    .wdata  (wdata),
    .rdata0 (rdata0),
    .rdata1 (rdata1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] mk_inst(input logic [7:0] wa, input logic [7:0] r1,
                                          input logic [7:0] r0);
    logic [39:0] junk;
    junk = {$urandom, 8'($urandom)};   // upper bits must be ignored
    return {junk, wa, r1, r0};
  endfunction

  // One clock of traffic with rst=1. Expectation is pushed before the edge
  // (read-first), popped and compared after it.
  task automatic step(input string tag, input bit we, input bit re, input logic [7:0] wa,
                      input logic [7:0] r1, input logic [7:0] r0, input logic [31:0] wd);
    logic [63:0] e;
    wren  = we;
    rden  = re;
    wdata = wd;
    inst  = mk_inst(wa, r1, r0);
    if (re) exp_q.push_back({model_mem[r1], model_mem[r0]});
    @(posedge clk);
    #1;
    if (we) begin
      model_mem[wa] = wd;
      model_vld[wa] = 1'b1;
    end
    if (re) begin
      e = exp_q.pop_front();
      last1 = e[63:32];
      last0 = e[31:0];
    end
    chk({tag, ".rdata0"}, rdata0, last0);
    chk({tag, ".rdata1"}, rdata1, last1);
    wren = 1'b0;
    rden = 1'b0;
  endtask

  initial begin
    logic [7:0] a, b, c;
    for (int i = 0; i < 256; i++) model_vld[i] = 1'b0;
    rst = 1'b0; wren = 1'b0; rden = 1'b1; inst = '0; wdata = '0;
    last0 = '0; last1 = '0;

    // Reset held with rden=1: outputs stay 0
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("reset.rdata0", rdata0, 32'h0);
      chk("reset.rdata1", rdata1, 32'h0);
    end
    rden = 1'b0;
    rst  = 1'b1;

    // Fill 0..5 with odd values; outputs must not move
    for (int i = 0; i < 6; i++) step("fill", 1, 0, 8'(i), 8'h0, 8'h0, 32'(2*i+1));

    // Dual reads
    step("rd01", 0, 1, 8'h0, 8'h01, 8'h00, 32'h0);
    chk("rd01.val1", rdata1, 32'd3);
    step("rd23", 0, 1, 8'h0, 8'h03, 8'h02, 32'h0);
    chk("rd23.val0", rdata0, 32'd5);
    step("rd45", 0, 1, 8'h0, 8'h05, 8'h04, 32'h0);
    chk("rd45.val0", rdata0, 32'd9);
    chk("rd45.val1", rdata1, 32'd11);

    // Hold with rden=0
    for (int i = 0; i < 10; i++) step("hold", 0, 0, 8'h0, 8'h0, 8'h0, 32'h0);
    chk("hold.val0", rdata0, 32'd9);
    chk("hold.val1", rdata1, 32'd11);

    // Same-address write/read collision: old data out, new data stored
    step("coll", 1, 1, 8'h02, 8'h03, 8'h02, 32'hDEAD_BEEF);
    chk("coll.old", rdata0, 32'd5);
    step("coll_rb", 0, 1, 8'h0, 8'h02, 8'h02, 32'h0);
    chk("coll_rb.new", rdata0, 32'hDEAD_BEEF);

    // Async reset mid-cycle; write on the edge inside reset is dropped
    step("pre_rst", 0, 1, 8'h0, 8'h01, 8'h00, 32'h0);
    #3;
    rst = 1'b0;
    #1;
    chk("arst.rdata0", rdata0, 32'h0);
    chk("arst.rdata1", rdata1, 32'h0);
    wren = 1'b1; rden = 1'b1; wdata = 32'h1234_5678; inst = mk_inst(8'h03, 8'h03, 8'h03);
    @(posedge clk); #1;
    chk("arst_hold.rdata0", rdata0, 32'h0);
    wren = 1'b0; rden = 1'b0;
    #2;
    rst = 1'b1;
    last0 = '0; last1 = '0;
    step("post_rst", 0, 1, 8'h0, 8'h03, 8'h03, 32'h0);
    chk("post_rst.retained", rdata1, 32'd7);

    // Random mix over a small address window, reading only defined entries
    for (int i = 0; i < 60; i++) begin
      a = 8'($urandom_range(0, 15));
      do b = 8'($urandom_range(0, 15)); while (!model_vld[b]);
      do c = 8'($urandom_range(0, 15)); while (!model_vld[c]);
      step("rand", 1'($urandom), 1'($urandom), a, b, c, $urandom);
    end
    // Full-range addresses: top entry
    step("top_wr", 1, 0, 8'hFF, 8'h0, 8'h0, 32'hA5A5_0FF0);
    step("top_rd", 0, 1, 8'h0, 8'hFF, 8'hFF, 32'h0);
    chk("top_rd.val", rdata0, 32'hA5A5_0FF0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
